// File: rtl/fifo_tx_drain_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter (and a future
// matching receiver): state encoding, default sizing, small state helpers.
package fifo_tx_drain_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    // States that last whole bit periods and therefore run the baud counter.
    function automatic logic is_timed_state(input tx_state_t s);
        logic r;
        case (s)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fifo_tx_drain_if.sv
// FIFO read port plus serial-side status of the drain transmitter.
// master = FIFO/system side, slave = the drain block.
interface fifo_tx_drain_if
    import fifo_tx_drain_pkg::*;
    #(parameter int DATA_W = DEF_DATA_W);

    logic              en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              tx;
    logic              busy;
    logic              frame_done;

    modport master (
        output en, fifo_empty, fifo_data,
        input  fifo_rd, tx, busy, frame_done
    );

    modport slave (
        input  en, fifo_empty, fifo_data,
        output fifo_rd, tx, busy, frame_done
    );

endinterface

// File: rtl/fifo_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, held at zero while
// cleared so every timed state starts its first bit from count 0.
module fifo_tx_baud_tick
    import fifo_tx_drain_pkg::*;
    #(
        parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
        localparam int CNT_W        = $clog2(CLKS_PER_BIT)
    ) (
        input  logic             clk,
        input  logic             rst,
        input  logic             i_clear,
        output logic             o_bit_end,
        output logic [CNT_W-1:0] o_cnt
    );

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Advance the bit-period count; wrap at the last cycle of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit_end = (r_cnt == CNT_LAST);
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/fifo_tx_drain.sv
// Pops one word at a time from the byte FIFO and sends it as an async serial
// frame: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
module fifo_tx_drain
    import fifo_tx_drain_pkg::*;
    #(
        parameter int DATA_W       = DEF_DATA_W,
        parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
        parameter int PARITY_EN    = 0
    ) (
        input  logic           clk,
        input  logic           rst,
        fifo_tx_drain_if.slave bus
    );

    localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int               BIT_W       = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
    // Count value one cycle before the end of a bit; lets frame_done be
    // registered yet still land on the final stop-bit cycle.
    localparam logic [CNT_W-1:0] CNT_PRE_END = CNT_W'(CLKS_PER_BIT - 2);
    localparam bit               PAR_ON      = (PARITY_EN != 32'sd0);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx;
    logic              r_fifo_rd;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_bit_end;
    logic              w_baud_clear;
    logic [CNT_W-1:0]  w_baud_cnt;
    logic [DATA_W-1:0] w_shift_next;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign w_baud_clear = !is_timed_state(r_state);
    assign w_shift_next = r_shift >> 1;

    fifo_tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_baud_clear),
        .o_bit_end (w_bit_end),
        .o_cnt     (w_baud_cnt)
    );

    // Frame FSM; outputs are registered with the value of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_cnt    <= '0;
            r_tx         <= 1'b1;
            r_fifo_rd    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx         <= 1'b1;
                    r_frame_done <= 1'b0;
                    if (bus.en && !bus.fifo_empty) begin
                        r_state   <= ST_POP;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_fifo_rd <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                ST_POP: begin
                    r_state   <= ST_LOAD;
                    r_fifo_rd <= 1'b0;
                end
                ST_LOAD: begin
                    // FIFO data is valid here: it was registered on the pop edge.
                    r_shift   <= bus.fifo_data;
                    r_parity  <= even_parity(bus.fifo_data);
                    r_bit_cnt <= '0;
                    r_state   <= ST_START;
                    r_tx      <= 1'b0;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_state <= ST_START;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            if (PAR_ON) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_state <= ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b0;
                    end else begin
                        r_frame_done <= (w_baud_cnt == CNT_PRE_END);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_tx         <= 1'b1;
                    r_fifo_rd    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd    = r_fifo_rd;
    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Bench for fifo_tx_drain: two instances (parity off / parity on) driven in
// lock-step from a FIFO model, each checked cycle by cycle against an expected
// waveform expanded from the frame format.
module tb_fifo_tx_drain;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic       en_v  [2];
    logic       emp_v [2];
    logic [7:0] dat_v [2];
    logic [3:0] outs  [2];   // {fifo_rd, tx, busy, frame_done}

    fifo_tx_drain_if #(.DATA_W(DW)) bus0 ();
    fifo_tx_drain_if #(.DATA_W(DW)) bus1 ();

    assign bus0.en         = en_v[0];
    assign bus0.fifo_empty = emp_v[0];
    assign bus0.fifo_data  = dat_v[0];
    assign bus1.en         = en_v[1];
    assign bus1.fifo_empty = emp_v[1];
    assign bus1.fifo_data  = dat_v[1];
    assign outs[0] = {bus0.fifo_rd, bus0.tx, bus0.busy, bus0.frame_done};
    assign outs[1] = {bus1.fifo_rd, bus1.tx, bus1.busy, bus1.frame_done};

    fifo_tx_drain #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
        .clk (clk), .rst (rst_v[0]), .bus (bus0)
    );
    fifo_tx_drain #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
        .clk (clk), .rst (rst_v[1]), .bus (bus1)
    );

    logic [7:0] fq     [2][$];  // words held by the FIFO (popped by DUT fifo_rd)
    logic [7:0] mq     [2][$];  // words the model expects to send, in order
    logic [3:0] eq     [2][$];  // expected outputs for upcoming cycles
    int         rd_cyc [2][$];
    bit         armed  [2];
    int         cyc;
    int         n_checks;
    int         n_errors;

    task automatic check_eq(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", tag, k, cyc, got, exp);
        end
    endtask

    // Expected outputs for a full frame: POP, LOAD, then each serial bit held CPB cycles.
    function automatic void expand(input int k, input logic [7:0] w);
        int nbits;
        nbits = 2 + DW + k;
        eq[k].push_back(4'b1110);
        eq[k].push_back(4'b0110);
        for (int b = 0; b < nbits; b++) begin
            logic bv;
            if (b == 0)                      bv = 1'b0;
            else if (b <= DW)                bv = w[b-1];
            else if (k == 1 && b == DW + 1)  bv = ^w;
            else                             bv = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                eq[k].push_back({1'b0, bv, 1'b1, (b == nbits - 1 && c == CPB - 1)});
            end
        end
    endfunction

    task automatic push_word(input logic [7:0] w);
        for (int k = 0; k < 2; k++) begin
            fq[k].push_back(w);
            mq[k].push_back(w);
            emp_v[k] = 1'b0;
        end
    endtask

    task automatic set_in(input logic r, input logic e);
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = r;
            en_v[k]  = e;
        end
    endtask

    // One clock: check at negedge, decide model transition, FIFO update after posedge.
    task automatic cycle();
        bit pop_now [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [3:0] exp;
            bit         idle_now;
            if (eq[k].size() == 0) begin
                exp      = 4'b0100;
                idle_now = 1'b1;
            end else begin
                exp      = eq[k].pop_front();
                idle_now = 1'b0;
            end
            if (armed[k]) check_eq("outs", k, outs[k], exp);
            pop_now[k] = (outs[k][3] === 1'b1);
            if (pop_now[k]) rd_cyc[k].push_back(cyc);
            if (rst_v[k]) begin
                eq[k].delete();
                armed[k] = 1'b1;
            end else if (armed[k] && idle_now && en_v[k] && !emp_v[k]) begin
                if (mq[k].size() > 0) expand(k, mq[k].pop_front());
                else check_eq("fifo_level", k, fq[k].size(), mq[k].size());
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (pop_now[k] && fq[k].size() > 0) dat_v[k] = fq[k].pop_front();
            emp_v[k] = (fq[k].size() == 0);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((eq[0].size() > 0 || eq[1].size() > 0 || !emp_v[0] || !emp_v[1]) && n < max) begin
            cycle();
            n++;
        end
        check_eq("drain_bound", 0, (n < max), 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int k = 0; k < 2; k++) begin
            armed[k] = 1'b0;
            dat_v[k] = 8'h00;
            emp_v[k] = 1'b1;
        end

        // Reset with data present and en high, then single word 0xA5.
        set_in(1'b1, 1'b1);
        push_word(8'hA5);
        run(2);
        set_in(1'b0, 1'b1);
        run(60);

        // Back-to-back 0x00 then 0xFF: two pops one frame + 3 idle cycles apart.
        for (int k = 0; k < 2; k++) rd_cyc[k].delete();
        push_word(8'h00);
        push_word(8'hFF);
        run(110);
        for (int k = 0; k < 2; k++) begin
            check_eq("pop_count", k, rd_cyc[k].size(), 2);
            if (rd_cyc[k].size() == 2)
                check_eq("pop_gap", k, rd_cyc[k][1] - rd_cyc[k][0], (2 + DW + k) * CPB + 3);
        end

        // Empty FIFO with en high; en low with data; en dropped mid-frame.
        run(100);
        set_in(1'b0, 1'b0);
        push_word(8'h3C);
        run(20);
        set_in(1'b0, 1'b1);
        run(10);
        set_in(1'b0, 1'b0);
        run(60);

        // Reset during data bit 3, then a clean frame with the next word.
        set_in(1'b0, 1'b1);
        push_word(8'h96);
        run(20);
        set_in(1'b1, 1'b1);
        run(1);
        set_in(1'b0, 1'b1);
        push_word(8'h5A);
        run(60);

        // Parity words: 0x07 (odd weight) and 0x03 (even weight).
        push_word(8'h07);
        push_word(8'h03);
        run(110);

        // Randomized traffic, enables and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 24) == 0) push_word(8'($urandom));
            cycle();
        end
        set_in(1'b0, 1'b1);
        drain(5000);
        run(5);
        for (int k = 0; k < 2; k++) check_eq("fifo_level_end", k, fq[k].size(), mq[k].size());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
